// File: rtl/bram_out_pipe.sv
// ---------------------------------------------------------------------------
// bram_out_pipe
//
// Optional output register stage placed after a block-RAM read register.
// With DEPTH=0 the read data passes straight through; with DEPTH=1 one extra
// resettable register is inserted, which synthesis can absorb into the
// BRAM's built-in output register.
//
// Parameters:
//   DEPTH  number of extra register stages (0 or 1)
//   DATA   data width in bits
//
// Ports:
//   clk     clock, rising edge
//   resetb  asynchronous active-low reset, clears the register stage
//   din     read data from the RAM read register
//   dout    read data presented to the user
// ---------------------------------------------------------------------------
module bram_out_pipe #(
   parameter int DEPTH = 0,
   parameter int DATA  = 8
) (
   input  logic            clk,
   input  logic            resetb,
   input  logic [DATA-1:0] din,
   output logic [DATA-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_bypass
         // No extra stage: the RAM read register already clears on reset,
         // so a plain wire keeps the reset behaviour intact.
         logic unused_pipe;
         assign unused_pipe = &{1'b0, clk, resetb};
         assign dout = din;
      end else begin : g_reg
         logic [DATA-1:0] q;

         // Second output stage; cleared with the read register so the
         // whole read path shows zero while reset is asserted.
         always_ff @(posedge clk or negedge resetb) begin
            if (!resetb) begin
               q <= '0;
            end else begin
               q <= din;
            end
         end

         assign dout = q;
      end
   endgenerate

endmodule

// File: rtl/inferable_dual_port_bram.sv
// ---------------------------------------------------------------------------
// inferable_dual_port_bram
//
// True dual-port synchronous RAM coded for block-RAM inference. Both ports
// share one clock and can each read and write every cycle. Reads are
// read-first (old data is returned when the same address is written on the
// same edge, from either port). When both ports write the same address on
// one edge, port B's data is kept.
//
// Parameters:
//   OREG  0: read latency 1 cycle; 1: extra output register, latency 2
//   DATA  data word width in bits
//   ADDR  address width in bits, depth = 2**ADDR
//
// Ports:
//   clk     clock for both ports, rising edge
//   resetb  asynchronous active-low reset (output/read registers only)
//   a_wr    port A write enable
//   a_addr  port A address
//   a_din   port A write data
//   a_dout  port A read data
//   b_wr    port B write enable
//   b_addr  port B address
//   b_din   port B write data
//   b_dout  port B read data
// ---------------------------------------------------------------------------
module inferable_dual_port_bram #(
   parameter int OREG = 0,
   parameter int DATA = 8,
   parameter int ADDR = 8
) (
   input  logic            clk,
   input  logic            resetb,
   input  logic            a_wr,
   input  logic [ADDR-1:0] a_addr,
   input  logic [DATA-1:0] a_din,
   output logic [DATA-1:0] a_dout,
   input  logic            b_wr,
   input  logic [ADDR-1:0] b_addr,
   input  logic [DATA-1:0] b_din,
   output logic [DATA-1:0] b_dout
);

   localparam int DEPTH = 1 << ADDR;

   // Contents start at zero from configuration; reset never touches them.
   logic [DATA-1:0] mem [0:DEPTH-1] = '{default: '0};

   logic [DATA-1:0] a_rd;
   logic [DATA-1:0] b_rd;

   // Both ports write from this one process so that a same-address
   // collision resolves deterministically: B's assignment comes last and
   // wins. No reset here, otherwise the array could not map to BRAM.
   always_ff @(posedge clk) begin
      if (a_wr) begin
         mem[a_addr] <= a_din;
      end
      if (b_wr) begin
         mem[b_addr] <= b_din;
      end
   end

   // Port A read register. It samples the array before this edge's writes
   // land, which gives read-first behaviour for both same-port and
   // cross-port accesses.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         a_rd <= '0;
      end else begin
         a_rd <= mem[a_addr];
      end
   end

   // Port B read register, same structure as port A.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         b_rd <= '0;
      end else begin
         b_rd <= mem[b_addr];
      end
   end

   bram_out_pipe #(
      .DEPTH (OREG),
      .DATA  (DATA)
   ) u_pipe_a (
      .clk    (clk),
      .resetb (resetb),
      .din    (a_rd),
      .dout   (a_dout)
   );

   bram_out_pipe #(
      .DEPTH (OREG),
      .DATA  (DATA)
   ) u_pipe_b (
      .clk    (clk),
      .resetb (resetb),
      .din    (b_rd),
      .dout   (b_dout)
   );

endmodule

// File: tb/tb_inferable_dual_port_bram.sv
// ---------------------------------------------------------------------------
// tb_inferable_dual_port_bram
//
// Self-checking bench for inferable_dual_port_bram (DATA=5, ADDR=8). A
// behavioural model keeps the memory contents as a plain array and each
// port's output as a latency queue of read results.
// ---------------------------------------------------------------------------
module tb_inferable_dual_port_bram;

   localparam int OREG  = 0;
   localparam int DATA  = 5;
   localparam int ADDR  = 8;
   localparam int DEPTH = 256;
   localparam int LAT   = OREG + 1;

   logic            clk = 1'b0;
   logic            resetb = 1'b0;
   logic            a_wr = 1'b0;
   logic [ADDR-1:0] a_addr = '0;
   logic [DATA-1:0] a_din = '0;
   logic [DATA-1:0] a_dout;
   logic            b_wr = 1'b0;
   logic [ADDR-1:0] b_addr = '0;
   logic [DATA-1:0] b_din = '0;
   logic [DATA-1:0] b_dout;

   int checks = 0;
   int errors = 0;

   logic [DATA-1:0] model_mem [DEPTH];
   logic [DATA-1:0] pipe_a [$];
   logic [DATA-1:0] pipe_b [$];

   inferable_dual_port_bram #(
      .OREG (OREG),
      .DATA (DATA),
      .ADDR (ADDR)
   ) dut (
      .clk    (clk),
      .resetb (resetb),
      .a_wr   (a_wr),
      .a_addr (a_addr),
      .a_din  (a_din),
      .a_dout (a_dout),
      .b_wr   (b_wr),
      .b_addr (b_addr),
      .b_din  (b_din),
      .b_dout (b_dout)
   );

   always #5 clk = ~clk;

   // While reset is low every output stage holds zero.
   task automatic resetModel();
      pipe_a = {};
      pipe_b = {};
      for (int k = 0; k < LAT; k++) begin
         pipe_a.push_back('0);
         pipe_b.push_back('0);
      end
   endtask

   // One clock edge of the model: reads see old contents, then A's write,
   // then B's write (so B wins a collision).
   task automatic modelEdge();
      logic [DATA-1:0] ra;
      logic [DATA-1:0] rb;
      if (resetb) begin
         ra = model_mem[a_addr];
         rb = model_mem[b_addr];
         pipe_a.push_front(ra);
         void'(pipe_a.pop_back());
         pipe_b.push_front(rb);
         void'(pipe_b.pop_back());
      end
      if (a_wr) model_mem[a_addr] = a_din;
      if (b_wr) model_mem[b_addr] = b_din;
   endtask

   // The model follows every edge and every reset assertion.
   always @(posedge clk) modelEdge();

   // Reset assertion clears the output stages immediately.
   always @(negedge resetb) resetModel();

   task automatic checkConst(input string tag, input logic [DATA-1:0] observed,
                             input logic [DATA-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [DATA-1:0] ea;
      logic [DATA-1:0] eb;
      ea = pipe_a[$];
      eb = pipe_b[$];
      checks++;
      assert (a_dout === ea) else begin
         errors++;
         $error("[TB] FAIL %s_a observed=%0h expected=%0h", tag, a_dout, ea);
      end
      checks++;
      assert (b_dout === eb) else begin
         errors++;
         $error("[TB] FAIL %s_b observed=%0h expected=%0h", tag, b_dout, eb);
      end
   endtask

   // Drive one cycle of port inputs, let the edge happen, check both ports.
   task automatic applyStimulus(input logic aw, input logic [ADDR-1:0] aa,
                                input logic [DATA-1:0] ad, input logic bw,
                                input logic [ADDR-1:0] ba,
                                input logic [DATA-1:0] bd, input string tag);
      @(negedge clk);
      a_wr   = aw;
      a_addr = aa;
      a_din  = ad;
      b_wr   = bw;
      b_addr = ba;
      b_din  = bd;
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   // Hold a read address on port A long enough for the data to emerge.
   task automatic readA(input logic [ADDR-1:0] addr, input logic [DATA-1:0] expected,
                        input string tag);
      for (int k = 0; k < LAT; k++) begin
         applyStimulus(1'b0, addr, '0, 1'b0, '0, '0, tag);
      end
      checkConst(tag, a_dout, expected);
   endtask

   initial begin
      logic [ADDR-1:0] addr_v;
      logic [DATA-1:0] data_v;
      int              k;

      for (int m = 0; m < DEPTH; m++) model_mem[m] = '0;
      resetModel();

      // Reset state and untouched contents.
      repeat (3) @(negedge clk);
      checkConst("rst_a", a_dout, '0);
      checkConst("rst_b", b_dout, '0);
      resetb = 1'b1;
      readA(8'h10, 5'h00, "init");

      // Write on B, read on A.
      applyStimulus(1'b0, '0, '0, 1'b1, 8'h2A, 5'h13, "wrb");
      readA(8'h2A, 5'h13, "b2a");

      // Read-first across ports.
      applyStimulus(1'b0, '0, '0, 1'b1, 8'h05, 5'h07, "pre");
      applyStimulus(1'b0, 8'h05, '0, 1'b1, 8'h05, 5'h1F, "rfirst");
      if (LAT == 2) applyStimulus(1'b0, 8'h05, '0, 1'b0, '0, '0, "rfirst");
      checkConst("rfirst_old", a_dout, 5'h07);
      readA(8'h05, 5'h1F, "rfirst_new");

      // Same-port read-first on B.
      applyStimulus(1'b0, '0, '0, 1'b1, 8'h05, 5'h03, "bself");
      if (LAT == 2) applyStimulus(1'b0, '0, '0, 1'b0, 8'h05, '0, "bself");
      checkConst("bself_old", b_dout, 5'h1F);

      // Write collision and simultaneous distinct writes.
      applyStimulus(1'b1, 8'hFF, 5'h01, 1'b1, 8'hFF, 5'h02, "coll");
      readA(8'hFF, 5'h02, "coll_b_wins");
      applyStimulus(1'b1, 8'h00, 5'h11, 1'b1, 8'h01, 5'h12, "dual");
      readA(8'h00, 5'h11, "dual_a");
      readA(8'h01, 5'h12, "dual_b");

      // Reset mid-stream: outputs drop at once, contents survive, and a
      // write during reset still lands.
      applyStimulus(1'b0, '0, '0, 1'b1, 8'h40, 5'h0A, "wr40");
      readA(8'h40, 5'h0A, "rd40");
      @(negedge clk);
      #2 resetb = 1'b0;
      #1;
      checkConst("midrst_a", a_dout, '0);
      checkConst("midrst_b", b_dout, '0);
      applyStimulus(1'b0, 8'h40, '0, 1'b1, 8'h41, 5'h0C, "inrst");
      @(negedge clk);
      b_wr   = 1'b0;
      resetb = 1'b1;
      readA(8'h40, 5'h0A, "keep40");
      readA(8'h41, 5'h0C, "rstwr41");

      // Fill through B, then stream every address through A with wrap.
      for (int i = 0; i < DEPTH; i++) begin
         addr_v = i[7:0];
         data_v = i[4:0];
         applyStimulus(1'b0, '0, '0, 1'b1, addr_v, data_v, "fill");
      end
      for (int i = 0; i <= DEPTH; i++) begin
         addr_v = i[7:0];
         applyStimulus(1'b0, addr_v, '0, 1'b0, '0, '0, "stream");
         if (i >= LAT - 1) begin
            k = (i - LAT + 1) & 31;
            data_v = k[4:0];
            checkConst("stream_seq", a_dout, data_v);
         end
      end

      // Random traffic on a narrow address window to provoke collisions.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                       5'($urandom), 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 7)), 5'($urandom), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inferable_dual_port_bram.md
Name: inferable_dual_port_bram

Overview:
Generic true dual-port synchronous RAM written so FPGA synthesis infers block RAM. It has two independent read/write ports (A and B) sharing one clock, and an optional output pipeline register. Used as a lookup table, e.g. a per-address latency table: port B is written by a configuration interface and port A is read every cycle by a datapath.

Parameters:
OREG, 0, output register enable; 0 gives read latency 1 cycle, 1 adds a second register stage for latency 2.
DATA, 8, data word width in bits (>=1).
ADDR, 8, address width in bits; depth = 2**ADDR words.

Ports:
clk  input  1  clock for both ports; all logic on its rising edge
resetb  input  1  reset, asynchronous, active-low; clock clk
a_wr  input  1  port A write enable
a_addr  input  ADDR  port A address
a_din  input  DATA  port A write data
a_dout  output  DATA  port A read data
b_wr  input  1  port B write enable
b_addr  input  ADDR  port B address
b_din  input  DATA  port B write data
b_dout  output  DATA  port B read data

Behaviour:
- Storage: array of 2**ADDR words of DATA bits, initialised to all zeros at configuration/time zero. resetb does NOT clear the array.
- Reset: while resetb=0, a_dout, b_dout and all internal read/pipeline registers are 0 (asynchronous assert, synchronous release on next clk edge).
- Write: on a rising clk edge with x_wr=1, mem[x_addr] <= x_din. Writes are visible to reads sampled on later edges.
- Read: every edge, each port samples mem[x_addr], whether or not it writes. There is no read enable.
- OREG=0: x_dout valid 1 cycle after the address is presented, i.e. a registered synchronous read.
- OREG=1: an extra register is added; x_dout is valid 2 cycles after the address.
- Same-port read during write: read-first. x_dout shows the old contents of the address.
- Cross-port: if A reads an address that B writes on the same edge (or the reverse), the reader gets the old data.
- Write collision: both ports write the same address on the same edge. Port B's data is stored. This is deterministic; no X is produced.
- Writes to different addresses on the same edge both complete.
- No address range checking is needed: the full 2**ADDR space is valid, and a_addr/b_addr use only their ADDR bits.
- Reset mid-operation: outputs drop to 0 immediately. A write on the edge coinciding with resetb=0 is still allowed to complete, since the memory is unaffected by reset. The first read data after release follows normal latency.
- Coding: the memory array is written without reset and the dout registers with reset, so synthesis maps to BRAM with output registers. Both ports write the array from one clocked process so the collision priority holds.

Decomposition:
- No shared package is needed: the block is parameter-only, with no typedefs or constants.
- One sub-module is natural: bram_out_pipe (DATA-wide, resettable, depth 0 or 1 by OREG), instantiated once per port.
- The core array and its port logic stay in the top module.

Test Plan:
- Reset and initial contents (DATA=5, ADDR=8, OREG=0): hold resetb=0 -> a_dout=b_dout=0. Release, read A addr 0x10 -> a_dout=0 one cycle later.
- Write B then read A: B writes 0x13 to addr 0x2A; next cycle A reads 0x2A -> a_dout=0x13 exactly 1 cycle after the address (2 cycles with OREG=1).
- Read-first and cross-port: mem[0x05]=0x07. On one edge B writes 0x1F to 0x05 while A reads 0x05 -> a_dout=0x07. Next read -> 0x1F.
- Write collision: same edge A writes 0x01 and B writes 0x02 to addr 0xFF -> subsequent read gives 0x02. Different addresses 0x00/0x01 -> both stored.
- Reset mid-stream: after writing addr 0x40=0x0A, pulse resetb low for 1 cycle -> outputs go 0 asynchronously. After release, reading 0x40 gives 0x0A (contents preserved).
- Back-to-back streaming: A reads addresses 0..255 on consecutive cycles after B fills mem[i]=i[4:0] -> a_dout sequence equals i[4:0] with constant latency and no bubbles, including the 255->0 wrap.
